// File: rtl/stack_seq_if.sv
// stack_seq_if: request/response, SP-register and stack-memory bus between a
// sequencer client (master) and the stack_seq block (slave).
interface stack_seq_if;
  // Op request / handshake
  logic        op_valid;
  logic        op_ready;
  logic [1:0]  op_code;
  logic [15:0] push_data;
  logic [15:0] ret_pc;
  // SP register interface
  logic [15:0] reg_SP_out;
  logic [1:0]  MSP;
  logic        sp_we;
  // Stack memory interface
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [15:0] mem_rdata;
  // Pop results and status
  logic [15:0] pop_data;
  logic        pop_valid;
  logic        pop_is_sr;
  logic        done;
  logic        stack_fault;

  modport master (
    output op_valid, op_code, push_data, ret_pc, reg_SP_out, mem_rdata,
    input  op_ready, MSP, sp_we, mem_addr, mem_wdata, mem_we, mem_re,
           pop_data, pop_valid, pop_is_sr, done, stack_fault
  );

  modport slave (
    input  op_valid, op_code, push_data, ret_pc, reg_SP_out, mem_rdata,
    output op_ready, MSP, sp_we, mem_addr, mem_wdata, mem_we, mem_re,
           pop_data, pop_valid, pop_is_sr, done, stack_fault
  );
endinterface

// File: rtl/stack_seq.sv
// stack_seq: PUSH/POP/CALL/RETI stack sequencer driving an external SP
// register (via MSP/sp_we) and a word-wide stack memory with one-cycle read
// latency. Optional stack-limit check enabled by macro STACK_LIMIT_CHK_EN.
module stack_seq #(
  parameter logic [15:0] STACK_LIMIT = 16'h0200
) (
  input  logic      clk,
  input  logic      rst_n,
  stack_seq_if.slave bus
);

  typedef enum logic [1:0] {
    OP_PUSH = 2'b00,
    OP_POP  = 2'b01,
    OP_CALL = 2'b10,
    OP_RETI = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    MSP_HOLD = 2'd0,
    MSP_DEC  = 2'd1,
    MSP_INC  = 2'd2
  } msp_e;

`ifdef STACK_LIMIT_CHK_EN
  typedef enum logic [2:0] {IDLE, DEC, WR, RD, INC, FAULT} state_e;
`else
  typedef enum logic [2:0] {IDLE, DEC, WR, RD, INC} state_e;
`endif

  state_e      state_q, state_d;
  op_e         op_q, op_d;
  logic [15:0] data_q, data_d;
  logic        sr_done_q, sr_done_d;   // RETI: SR word already popped

  logic        op_ready_q, op_ready_d;
  msp_e        msp_q, msp_d;
  logic        sp_we_q, sp_we_d;
  logic        mem_we_q, mem_we_d;
  logic        mem_re_q, mem_re_d;
  logic [15:0] mem_wdata_q, mem_wdata_d;
  logic        pop_valid_q, pop_valid_d;
  logic        pop_is_sr_q, pop_is_sr_d;
  logic        done_q, done_d;

  logic [15:0] sp_even;
  logic        unused_ok;

  assign sp_even = {bus.reg_SP_out[15:1], 1'b0};

`ifdef STACK_LIMIT_CHK_EN
  logic        stack_fault_q, stack_fault_d;
  logic        limit_hit;

  // (sp_even - 2) < STACK_LIMIT without wrap, evaluated as sp_even < LIMIT + 2
  assign limit_hit = {1'b0, sp_even} < ({1'b0, STACK_LIMIT} + 17'd2);
  assign bus.stack_fault = stack_fault_q;
  assign unused_ok = bus.reg_SP_out[0];
`else
  assign bus.stack_fault = 1'b0;
  assign unused_ok = ^{bus.reg_SP_out[0], STACK_LIMIT};
`endif

  // Next-state sequencing and operand capture on acceptance
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    data_d    = data_q;
    sr_done_d = sr_done_q;
    case (state_q)
      IDLE: begin
        if (bus.op_valid) begin
          op_d      = op_e'(bus.op_code);
          data_d    = (op_e'(bus.op_code) == OP_CALL) ? bus.ret_pc : bus.push_data;
          sr_done_d = 1'b0;
          if (op_d == OP_PUSH || op_d == OP_CALL) begin
`ifdef STACK_LIMIT_CHK_EN
            state_d = limit_hit ? FAULT : DEC;
`else
            state_d = DEC;
`endif
          end else begin
            state_d = RD;
          end
        end
      end
      DEC: state_d = WR;
      WR:  state_d = IDLE;
      RD:  state_d = INC;
      INC: begin
        if (op_q == OP_RETI && !sr_done_q) begin
          sr_done_d = 1'b1;
          state_d   = RD;
        end else begin
          state_d   = IDLE;
        end
      end
`ifdef STACK_LIMIT_CHK_EN
      FAULT: state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs decoded from the state being entered
  always_comb begin
    op_ready_d  = 1'b0;
    msp_d       = MSP_HOLD;
    sp_we_d     = 1'b0;
    mem_we_d    = 1'b0;
    mem_re_d    = 1'b0;
    mem_wdata_d = '0;
    pop_valid_d = 1'b0;
    pop_is_sr_d = 1'b0;
    done_d      = 1'b0;
`ifdef STACK_LIMIT_CHK_EN
    stack_fault_d = 1'b0;
`endif
    case (state_d)
      IDLE: op_ready_d = 1'b1;
      DEC: begin
        msp_d   = MSP_DEC;
        sp_we_d = 1'b1;
      end
      WR: begin
        mem_we_d    = 1'b1;
        mem_wdata_d = data_d;
        done_d      = 1'b1;
      end
      RD: mem_re_d = 1'b1;
      INC: begin
        msp_d       = MSP_INC;
        sp_we_d     = 1'b1;
        pop_valid_d = 1'b1;
        pop_is_sr_d = (op_d == OP_RETI) && !sr_done_d;
        done_d      = !((op_d == OP_RETI) && !sr_done_d);
      end
`ifdef STACK_LIMIT_CHK_EN
      FAULT: begin
        stack_fault_d = 1'b1;
        done_d        = 1'b1;
      end
`endif
      default: op_ready_d = 1'b0;
    endcase
  end

  // State, operand and output registers; reset abandons any in-flight op
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= OP_PUSH;
      data_q      <= '0;
      sr_done_q   <= 1'b0;
      op_ready_q  <= 1'b1;
      msp_q       <= MSP_HOLD;
      sp_we_q     <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      mem_wdata_q <= '0;
      pop_valid_q <= 1'b0;
      pop_is_sr_q <= 1'b0;
      done_q      <= 1'b0;
`ifdef STACK_LIMIT_CHK_EN
      stack_fault_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      data_q      <= data_d;
      sr_done_q   <= sr_done_d;
      op_ready_q  <= op_ready_d;
      msp_q       <= msp_d;
      sp_we_q     <= sp_we_d;
      mem_we_q    <= mem_we_d;
      mem_re_q    <= mem_re_d;
      mem_wdata_q <= mem_wdata_d;
      pop_valid_q <= pop_valid_d;
      pop_is_sr_q <= pop_is_sr_d;
      done_q      <= done_d;
`ifdef STACK_LIMIT_CHK_EN
      stack_fault_q <= stack_fault_d;
`endif
    end
  end

  assign bus.op_ready  = op_ready_q;
  assign bus.MSP       = msp_q;
  assign bus.sp_we     = sp_we_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_re    = mem_re_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.pop_valid = pop_valid_q;
  assign bus.pop_is_sr = pop_is_sr_q;
  assign bus.done      = done_q;

  // Address follows the live SP so WR sees the already-decremented value
  // and the second RETI read sees the already-incremented value.
  assign bus.mem_addr = (state_q == WR || state_q == RD) ? sp_even : '0;
  // Read data arrives in INC, one cycle after mem_re
  assign bus.pop_data = (state_q == INC) ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_stack_seq.sv
// tb_stack_seq: directed bench for stack_seq with an SP-register and stack
// memory environment, a transaction-level expected-output model and a
// per-cycle compare process, plus literal end-state checks.
module tb_stack_seq;
  localparam logic [1:0] PUSH = 2'b00, POP = 2'b01, CALL = 2'b10, RETI = 2'b11;
  localparam logic [15:0] LIMIT = 16'h0200;

  typedef struct {
    logic        op_ready;
    logic [1:0]  msp;
    logic        sp_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [15:0] pop_data;
    logic        pop_valid;
    logic        pop_is_sr;
    logic        done;
    logic        stack_fault;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  stack_seq_if bus();

  stack_seq #(.STACK_LIMIT(LIMIT)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  // Environment: SP register and stack memory
  logic [15:0] sp_reg = 16'h0000;
  logic        sp_ld = 1'b0;
  logic [15:0] sp_ld_val = 16'h0000;
  logic [15:0] mem [0:32767];
  logic [15:0] rdata = 16'h0000;

  always @(posedge clk) begin
    if (sp_ld) sp_reg <= sp_ld_val;
    else if (bus.sp_we) begin
      if (bus.MSP == 2'd1) sp_reg <= sp_reg - 16'd2;
      else if (bus.MSP == 2'd2) sp_reg <= sp_reg + 16'd2;
    end
    if (bus.mem_we) mem[bus.mem_addr[15:1]] <= bus.mem_wdata;
    if (bus.mem_re) rdata <= mem[bus.mem_addr[15:1]];
  end

  assign bus.reg_SP_out = sp_reg;
  assign bus.mem_rdata  = rdata;

  // Model state
  logic [15:0] sp_m = 16'h0000;
  logic [15:0] mmod [logic [15:0]];
  exp_t        expq [$];

  // Observations used by literal checks
  int          wr_cnt = 0;
  int          fault_cnt = 0;
  logic [15:0] last_wr_addr = 16'h0, last_wr_data = 16'h0, last_rd_addr = 16'h0;
  logic [15:0] last_pop = 16'h0, last_sr = 16'h0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic exp_t zero_v();
    exp_t e;
    e = '{op_ready: 1'b0, msp: 2'd0, sp_we: 1'b0, mem_addr: 16'h0, mem_wdata: 16'h0,
          mem_we: 1'b0, mem_re: 1'b0, pop_data: 16'h0, pop_valid: 1'b0,
          pop_is_sr: 1'b0, done: 1'b0, stack_fault: 1'b0};
    return e;
  endfunction

  function automatic bit will_fault(input logic [15:0] sp);
`ifdef STACK_LIMIT_CHK_EN
    return (int'({sp[15:1], 1'b0}) - 2) < int'(LIMIT);
`else
    return 1'b0 && sp[0];
`endif
  endfunction

  // Per-cycle compare against the model's expected vector (idle when empty)
  always @(negedge clk) begin
    exp_t e;
    if (expq.size() > 0) e = expq.pop_front();
    else begin
      e = zero_v();
      e.op_ready = 1'b1;
    end
    chk("op_ready", bus.op_ready, e.op_ready);
    chk("MSP", bus.MSP, e.msp);
    chk("sp_we", bus.sp_we, e.sp_we);
    chk("mem_addr", bus.mem_addr, e.mem_addr);
    chk("mem_wdata", bus.mem_wdata, e.mem_wdata);
    chk("mem_we", bus.mem_we, e.mem_we);
    chk("mem_re", bus.mem_re, e.mem_re);
    chk("pop_valid", bus.pop_valid, e.pop_valid);
    chk("pop_is_sr", bus.pop_is_sr, e.pop_is_sr);
    chk("done", bus.done, e.done);
    chk("stack_fault", bus.stack_fault, e.stack_fault);
    if (e.pop_valid) chk("pop_data", bus.pop_data, e.pop_data);
    if (bus.mem_we === 1'b1) begin
      wr_cnt++;
      last_wr_addr = bus.mem_addr;
      last_wr_data = bus.mem_wdata;
    end
    if (bus.mem_re === 1'b1) last_rd_addr = bus.mem_addr;
    if (bus.pop_valid === 1'b1) begin
      if (bus.pop_is_sr) last_sr = bus.pop_data;
      else last_pop = bus.pop_data;
    end
    if (bus.stack_fault === 1'b1) fault_cnt++;
  end

  task automatic set_sp(input logic [15:0] v);
    sp_ld_val = v;
    sp_ld = 1'b1;
    @(posedge clk); #1;
    sp_ld = 1'b0;
    sp_m = v;
  endtask

  task automatic exp_pop(input bit is_sr, input bit last);
    exp_t e;
    logic [15:0] s;
    s = {sp_m[15:1], 1'b0};
    e = zero_v();
    e.mem_addr = s;
    e.mem_re = 1'b1;
    expq.push_back(e);
    e = zero_v();
    e.pop_data = mmod.exists(s) ? mmod[s] : 16'h0;
    e.pop_valid = 1'b1;
    e.pop_is_sr = is_sr;
    e.msp = 2'd2;
    e.sp_we = 1'b1;
    e.done = last;
    expq.push_back(e);
    sp_m = sp_m + 16'd2;
  endtask

  // Issue one op in an idle cycle; garbage is driven while busy and must be ignored
  task automatic do_op(input logic [1:0] code, input logic [15:0] d);
    exp_t e;
    logic [15:0] s;
    int n;
    bus.op_valid  = 1'b1;
    bus.op_code   = code;
    bus.push_data = (code == CALL) ? 16'hDEAD : d;
    bus.ret_pc    = (code == CALL) ? d : 16'hBAD0;
    @(posedge clk); #1;
    s = {sp_m[15:1], 1'b0};
    n = 2;
    if (code == PUSH || code == CALL) begin
      if (will_fault(sp_m)) begin
        e = zero_v();
        e.stack_fault = 1'b1;
        e.done = 1'b1;
        expq.push_back(e);
        n = 1;
      end else begin
        e = zero_v();
        e.msp = 2'd1;
        e.sp_we = 1'b1;
        expq.push_back(e);
        e = zero_v();
        e.mem_addr = s - 16'd2;
        e.mem_wdata = d;
        e.mem_we = 1'b1;
        e.done = 1'b1;
        expq.push_back(e);
        mmod[s - 16'd2] = d;
        sp_m = sp_m - 16'd2;
      end
    end else if (code == POP) begin
      exp_pop(1'b0, 1'b1);
    end else begin
      exp_pop(1'b1, 1'b0);
      exp_pop(1'b0, 1'b1);
      n = 4;
    end
    bus.op_code   = ~code;
    bus.push_data = ~d;
    bus.ret_pc    = ~d;
    repeat (n) begin
      @(posedge clk); #1;
    end
    bus.op_valid = 1'b0;
  endtask

  int wr_before;

  initial begin
    bus.op_valid  = 1'b0;
    bus.op_code   = 2'b00;
    bus.push_data = 16'h0;
    bus.ret_pc    = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_op_ready", bus.op_ready, 16'h1);
    chk("reset_done", bus.done, 16'h0);
    chk("reset_sp_we", bus.sp_we, 16'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic PUSH at SP 0x0400
    set_sp(16'h0400);
    do_op(PUSH, 16'h1234);
    chk("push_addr", last_wr_addr, 16'h03FE);
    chk("push_data", last_wr_data, 16'h1234);
    chk("push_sp", sp_reg, 16'h03FE);

    // POP of a freshly pushed word
    set_sp(16'h0400);
    do_op(PUSH, 16'hBEEF);
    do_op(POP, 16'h0);
    chk("pop_addr", last_rd_addr, 16'h03FE);
    chk("pop_word", last_pop, 16'hBEEF);
    chk("pop_sp", sp_reg, 16'h0400);

    // RETI: SR at 0x03FC, PC at 0x03FE
    set_sp(16'h0400);
    do_op(PUSH, 16'hC000);
    do_op(PUSH, 16'h0008);
    do_op(RETI, 16'h0);
    chk("reti_sr", last_sr, 16'h0008);
    chk("reti_pc", last_pop, 16'hC000);
    chk("reti_sp", sp_reg, 16'h0400);

`ifndef STACK_LIMIT_CHK_EN
    // Odd SP and modulo-2^16 wrap
    set_sp(16'h0001);
    do_op(CALL, 16'hF00A);
    chk("call_addr", last_wr_addr, 16'hFFFE);
    chk("call_data", last_wr_data, 16'hF00A);
    chk("call_sp", sp_reg, 16'hFFFF);
    do_op(POP, 16'h0);
    chk("wrap_pop_addr", last_rd_addr, 16'hFFFE);
    chk("wrap_pop_word", last_pop, 16'hF00A);
    set_sp(16'h0002);
    do_op(PUSH, 16'h5A5A);
    chk("push0_addr", last_wr_addr, 16'h0000);
    do_op(POP, 16'h0);
    chk("pop0_addr", last_rd_addr, 16'h0000);
    chk("pop0_word", last_pop, 16'h5A5A);
    set_sp(16'h0000);
    do_op(PUSH, 16'h7777);
    chk("wrap_push_addr", last_wr_addr, 16'hFFFE);
    do_op(POP, 16'h0);
    chk("wrap_pop_sp", sp_reg, 16'h0000);
`else
    // Stack-limit check: 0x0200 faults, 0x0202 is the lowest legal push
    set_sp(16'h0200);
    wr_before = wr_cnt;
    do_op(PUSH, 16'h4444);
    chk("fault_seen", 16'(fault_cnt), 16'h1);
    chk("fault_no_wr", 16'(wr_cnt - wr_before), 16'h0);
    chk("fault_sp", sp_reg, 16'h0200);
    set_sp(16'h0202);
    do_op(CALL, 16'h1111);
    chk("limit_ok_addr", last_wr_addr, 16'h0200);
    chk("limit_ok_sp", sp_reg, 16'h0200);
    do_op(POP, 16'h0);
    chk("limit_pop", last_pop, 16'h1111);
`endif

    // Reset during DEC of a PUSH
    set_sp(16'h0400);
    wr_before = wr_cnt;
    bus.op_valid  = 1'b1;
    bus.op_code   = PUSH;
    bus.push_data = 16'h9999;
    @(posedge clk); #1;
    chk("dec_sp_we", bus.sp_we, 16'h1);
    chk("dec_msp", bus.MSP, 16'h1);
    #1;
    rst_n = 1'b0;
    expq.delete();
    bus.op_valid = 1'b0;
    #1;
    chk("rst_sp_we", bus.sp_we, 16'h0);
    chk("rst_msp", bus.MSP, 16'h0);
    chk("rst_op_ready", bus.op_ready, 16'h1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_no_wr", 16'(wr_cnt - wr_before), 16'h0);
    chk("rst_sp", sp_reg, 16'h0400);

    // Post-reset sanity op
    do_op(PUSH, 16'hA5A5);
    chk("post_rst_addr", last_wr_addr, 16'h03FE);
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/stack_seq.md
STACK_SEQ -- requirements
Module: stack_seq

Interface
REQ-001 SHALL have parameter STACK_LIMIT, default 16'h0200, lowest legal stack word address (used only with STACK_LIMIT_CHK_EN).
REQ-002 SHALL have port clk  in  1  sole clock, rising edge.
REQ-003 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port op_valid  in  1  stack op request.
REQ-005 SHALL have port op_ready  out  1  sequencer idle, able to accept.
REQ-006 SHALL have port op_code  in  2  2'b00 PUSH, 2'b01 POP, 2'b10 CALL, 2'b11 RETI.
REQ-007 SHALL have port push_data  in  16  word pushed by PUSH.
REQ-008 SHALL have port ret_pc  in  16  return PC pushed by CALL.
REQ-009 SHALL have port reg_SP_out  in  16  current SP register value.
REQ-010 SHALL have port MSP  out  2  SP-mux select: 0 hold, 1 SP-2, 2 SP+2.
REQ-011 SHALL have port sp_we  out  1  SP register write enable.
REQ-012 SHALL have ports mem_addr out 16, mem_wdata out 16, mem_we out 1, mem_re out 1, mem_rdata in 16 (data valid one cycle after mem_re).
REQ-013 SHALL have ports pop_data out 16, pop_valid out 1, pop_is_sr out 1 (popped word is SR), done out 1, stack_fault out 1.

Function
REQ-014 SHALL implement states IDLE, DEC, WR, RD, INC, FAULT; op_ready=1 only in IDLE.
REQ-015 SHALL accept an op when op_valid&&op_ready in IDLE, latching op_code and the data word (push_data for PUSH, ret_pc for CALL).
REQ-016 PUSH/CALL SHALL sequence IDLE->DEC->WR->IDLE; DEC drives MSP=1, sp_we=1; WR drives mem_addr={reg_SP_out[15:1],0}, mem_wdata=latched word, mem_we=1, done=1.
REQ-017 POP SHALL sequence IDLE->RD->INC->IDLE; RD drives mem_addr={reg_SP_out[15:1],0}, mem_re=1; INC registers pop_data=mem_rdata, pop_valid=1, MSP=2, sp_we=1, done=1.
REQ-018 RETI SHALL run RD->INC twice; first INC pop_is_sr=1 (SR), second pop_is_sr=0 (PC) with done=1; done SHALL NOT assert on the first INC.
REQ-019 Outside DEC/INC SHALL hold MSP=0, sp_we=0; MSP=3 SHALL never be driven.
REQ-020 mem_we, mem_re, pop_valid, done, stack_fault SHALL be single-cycle pulses, else 0; mem_addr/mem_wdata SHALL be 0 when unused.
REQ-021 Latency: accepted PUSH/CALL/POP SHALL assert done 2 cycles after acceptance, RETI 4 cycles; next op accepted the cycle after done.
REQ-022 Address arithmetic SHALL be modulo 2^16: SP 0x0000 pushes to 0xFFFE; SP 0xFFFE pops then SP becomes 0x0000; odd SP is treated as even.
REQ-023 op_valid and op_code changes outside IDLE SHALL be ignored.

Reset
REQ-024 rst_n low SHALL immediately force IDLE and all outputs to 0 except op_ready, which is 1 once in IDLE; an in-flight op SHALL be abandoned with no further SP or memory writes.

Configuration
REQ-025 With STACK_LIMIT_CHK_EN defined, an accepted PUSH/CALL whose {reg_SP_out[15:1],0}-2 (unsigned, no wrap) is below STACK_LIMIT SHALL go IDLE->FAULT->IDLE, pulsing stack_fault=1 and done=1 in FAULT, with no SP write and no memory write; POP/RETI are unchecked.
REQ-026 Without STACK_LIMIT_CHK_EN, stack_fault SHALL be constant 0, no FAULT state SHALL exist, and all pushes proceed per REQ-016.

Verification
REQ-027 SP=0x0400, PUSH push_data=0x1234 -> DEC: MSP=1, sp_we=1; WR: mem_addr=0x03FE, mem_wdata=0x1234, mem_we=1, done=1.
REQ-028 SP=0x03FE, POP with mem_rdata=0xBEEF -> RD mem_addr=0x03FE, mem_re=1; INC pop_data=0xBEEF, pop_valid=1, MSP=2, done=1.
REQ-029 SP=0x03FC, RETI, memory 0x03FC=0x0008, 0x03FE=0xC000 -> pop 0x0008 with pop_is_sr=1, then 0xC000 with pop_is_sr=0 and done; SP ends 0x0400.
REQ-030 SP=0x0001, CALL ret_pc=0xF00A (check off) -> write 0xF00A to 0xFFFE; SP=0x0000 POP -> read 0x0000.
REQ-031 STACK_LIMIT_CHK_EN, STACK_LIMIT=0x0200, SP=0x0200, PUSH -> stack_fault=1, done=1, sp_we=0, mem_we=0 throughout.
REQ-032 rst_n low during DEC of a PUSH -> outputs 0 immediately, op_ready=1, no mem_we pulse after release.
